// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: mode codes, per-mode seeds
// and the seed lookup used on mode changes and restarts.
package led_seq_pkg;

   localparam int LED_W = 16;

   localparam logic [2:0] MODE_OFF   = 3'd0;
   localparam logic [2:0] MODE_ROT   = 3'd1;
   localparam logic [2:0] MODE_BNC   = 3'd2;
   localparam logic [2:0] MODE_FILL  = 3'd3;
   localparam logic [2:0] MODE_BLINK = 3'd4;
   localparam logic [2:0] MODE_CNT   = 3'd5;

   localparam logic [LED_W-1:0] SEED_OFF     = 16'h0000;
   localparam logic [LED_W-1:0] SEED_ROT_FWD = 16'h0001;
   localparam logic [LED_W-1:0] SEED_ROT_REV = 16'h8000;
   localparam logic [LED_W-1:0] SEED_BNC     = 16'h0001;
   localparam logic [LED_W-1:0] SEED_FILL    = 16'h0001;
   localparam logic [LED_W-1:0] SEED_BLINK   = 16'hFFFF;
   localparam logic [LED_W-1:0] SEED_CNT     = 16'h0000;

   localparam logic [LED_W-1:0] RST_LED  = 16'h0001;
   localparam logic [2:0]       RST_MODE = MODE_ROT;

   // Reserved modes 6 and 7 fall through to the OFF seed.
   function automatic logic [LED_W-1:0] seed_for(input logic [2:0] m, input logic rev);
      logic [LED_W-1:0] seed;
      case (m)
         MODE_ROT:   seed = rev ? SEED_ROT_REV : SEED_ROT_FWD;
         MODE_BNC:   seed = SEED_BNC;
         MODE_FILL:  seed = SEED_FILL;
         MODE_BLINK: seed = SEED_BLINK;
         MODE_CNT:   seed = SEED_CNT;
         default:    seed = SEED_OFF;
      endcase
      return seed;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: a tick every P cycles, P = DIV_MAX >> (2*speed),
// never below 1. Pause freezes the count; clr forces it back to zero.
module led_tick_gen #(
   parameter int unsigned DIV_MAX = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   input  logic       pause,
   input  logic       clr,
   output logic       tick
);

   logic [31:0] r_cnt;
   logic [31:0] w_shift;
   logic [31:0] w_per;

   always_comb begin
      w_shift = 32'(DIV_MAX) >> {speed, 1'b0};
      w_per   = (w_shift == 32'd0) ? 32'd1 : w_shift;
   end

   // Compare with >= so a speed-up mid-count ticks immediately instead of overrunning.
   assign tick = ~pause && (r_cnt >= (w_per - 32'd1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= '0;
      end else if (!pause) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// Switch-configured LED pattern sequencer: synchronises the switches, detects
// restart edges and advances the selected pattern on each prescaler tick.
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int unsigned DIV_MAX = 5000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       sw,
   output logic [LED_W-1:0] ledr,
   output logic [2:0]       mode,
   output logic             step
);

   logic [7:0]       r_sw_meta;
   logic [7:0]       r_sw_sync;
   logic             r_restart_d;
   logic [LED_W-1:0] r_led;
   logic [2:0]       r_mode;
   logic             r_dir;
   logic             r_step;

   logic             w_restart;
   logic             w_tick;
   logic [2:0]       w_sel;
   logic             w_rev;
   logic [LED_W-1:0] w_led_nxt;
   logic [2:0]       w_mode_nxt;
   logic             w_dir_nxt;
   logic             w_step_nxt;

   assign w_sel     = r_sw_sync[2:0];
   assign w_rev     = r_sw_sync[6];
   assign w_restart = r_sw_sync[7] & ~r_restart_d;

   led_tick_gen #(
      .DIV_MAX (DIV_MAX)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .speed (r_sw_sync[4:3]),
      .pause (r_sw_sync[5]),
      .clr   (w_restart),
      .tick  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sw_meta   <= '0;
         r_sw_sync   <= '0;
         r_restart_d <= 1'b0;
      end else begin
         r_sw_meta   <= sw;
         r_sw_sync   <= r_sw_meta;
         r_restart_d <= r_sw_sync[7];
      end
   end

   always_comb begin
      w_led_nxt  = r_led;
      w_mode_nxt = r_mode;
      w_dir_nxt  = r_dir;
      w_step_nxt = 1'b0;
      if (w_restart) begin
         w_led_nxt  = seed_for(w_sel, w_rev);
         w_mode_nxt = w_sel;
         w_dir_nxt  = 1'b0;
      end else if (w_tick) begin
         w_step_nxt = 1'b1;
         if (w_sel != r_mode) begin
            w_led_nxt  = seed_for(w_sel, w_rev);
            w_mode_nxt = w_sel;
            w_dir_nxt  = 1'b0;
         end else begin
            case (r_mode)
               MODE_ROT: begin
                  w_led_nxt = w_rev ? {r_led[0], r_led[LED_W-1:1]}
                                    : {r_led[LED_W-2:0], r_led[LED_W-1]};
               end
               MODE_BNC: begin
                  // Direction flips on the step that lands on an end bit.
                  if (!r_dir) begin
                     w_led_nxt = {r_led[LED_W-2:0], 1'b0};
                     if (r_led[LED_W-2]) w_dir_nxt = 1'b1;
                  end else begin
                     w_led_nxt = {1'b0, r_led[LED_W-1:1]};
                     if (r_led[1]) w_dir_nxt = 1'b0;
                  end
               end
               MODE_FILL: begin
                  w_led_nxt = (&r_led) ? '0 : {r_led[LED_W-2:0], 1'b1};
               end
               MODE_BLINK: w_led_nxt = ~r_led;
               MODE_CNT:   w_led_nxt = r_led + 16'd1;
               default:    w_led_nxt = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_led  <= RST_LED;
         r_mode <= RST_MODE;
         r_dir  <= 1'b0;
         r_step <= 1'b0;
      end else begin
         r_led  <= w_led_nxt;
         r_mode <= w_mode_nxt;
         r_dir  <= w_dir_nxt;
         r_step <= w_step_nxt;
      end
   end

   assign ledr = r_led;
   assign mode = r_mode;
   assign step = r_step;

endmodule
